alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execution-side consumer of the 3-bit ALUControl code from the ALU control decoder.
- Accepts one operation (code plus two operands) over a valid/ready handshake and returns a registered result, zero flag and illegal-code flag over a second valid/ready handshake.
- Sits between the decode/operand-fetch path and writeback in the RISC core.
- Supports backpressure and, optionally, a multi-cycle multiply.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept an operation this cycle.
- alu_control  input  3  ALUControl code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 MUL (feature only), 110/111 reserved.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  registered flag, result == 0.
- illegal  output  1  registered flag, code not supported.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n.
- States:
  - IDLE: no result pending.
  - CALC: multiply in progress (feature only).
  - HOLD: result presented.
- Reset (rst_n low, async):
  - state=IDLE, out_valid=0, result=0, zero=0, illegal=0, internal operand/counter registers=0.
  - An operation in flight is aborted and no result is ever produced for it.
- in_ready:
  - 1 in IDLE.
  - 1 in HOLD when out_ready=1 (combinational pass-through, same-cycle retire and accept).
  - 0 in CALC.
- Accept occurs at a clk edge with in_valid && in_ready. alu_control/src_a/src_b sampled only then.
- Single-cycle ops (000–100, and reserved codes):
  - Result registered at the accept edge; state goes to HOLD and out_valid=1 from that edge.
  - Latency 1 cycle. Throughput 1 op/cycle when out_ready held high.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH, no carry/overflow output.
  - AND/OR are bitwise.
  - SLT is a signed two's-complement compare: result = {WIDTH-1 zeros, (src_a <s src_b)}.
- Reserved codes (110, 111; also 101 without feature): result=0, zero=1, illegal=1, normal 1-cycle handshake. The unit never hangs.
- zero and illegal are registered alongside result and valid only while out_valid=1.
- HOLD:
  - result/zero/illegal/out_valid stable while out_ready=0.
  - out_valid && out_ready retires the result.
  - If no new accept in the same cycle: IDLE, out_valid=0 next edge, result/flags keep last value.
  - If a new accept occurs in the same cycle: remain HOLD with the new result.
- in_valid while in_ready=0 is ignored. Upstream must hold the request.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: ALU_MUL_EN
- Defined:
  - Code 101 = MUL, low WIDTH bits of the unsigned product src_a*src_b.
  - Accept edge loads the operands and enters CALC.
  - Iterative shift-add, one multiplier bit per cycle, over WIDTH edges.
  - At the WIDTH-th edge after accept: state=HOLD, out_valid=1, illegal=0, zero per product.
  - in_ready=0 throughout CALC.
  - Reset during CALC aborts to IDLE.
- Undefined:
  - 101 is treated as a reserved code (illegal=1, result=0).
  - No CALC state, counter or multiplier datapath is synthesised.

Test Plan:
- Reset, then ADD 0x0000_0005+0x0000_0003 with out_ready=1 -> out_valid 1 cycle after accept, result=0x0000_0008, zero=0, illegal=0.
- SUB 0x0000_0000-0x0000_0001, then SLT 0xFFFF_FFFF vs 0x0000_0001 back-to-back with out_ready=1 -> results 0xFFFF_FFFF then 0x0000_0001, one per cycle, in_ready stays 1.
- AND 0xF0F0_F0F0 & 0x0F0F_0F0F with out_ready=0 for 5 cycles -> result=0, zero=1 held stable, in_ready=0 until out_ready=1, then out_valid drops next edge.
- Code 111 with operands 0x1234/0x5678 -> result=0, zero=1, illegal=1, single-cycle response.
- ALU_MUL_EN: MUL 0x0001_0003*0x0000_0007 -> in_ready=0 for 32 cycles, out_valid at the 32nd edge after accept, result=0x0007_0015. Without the macro, the same stimulus gives illegal=1, result=0.
- rst_n pulsed low mid-HOLD (and mid-CALC with ALU_MUL_EN) -> out_valid drops immediately (async), all outputs 0, in_ready=1, no stale result after release.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ALU execution unit: registered ALU results behind valid/ready handshakes.
// Optional iterative multiply on code 101 when ALU_MUL_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

    state_t state;
    state_t next_state;

    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] op_result;
    logic             op_illegal;

    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        unique case (1'b1)
            (alu_control == 3'b000): op_result = src_a + src_b;
            (alu_control == 3'b001): op_result = src_a - src_b;
            (alu_control == 3'b010): op_result = src_a & src_b;
            (alu_control == 3'b011): op_result = src_a | src_b;
            (alu_control == 3'b100):
                op_result = {{(WIDTH-1){1'b0}},
                             ($signed(src_a) < $signed(src_b))};
            default: op_illegal = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;

    assign is_mul   = (alu_control == 3'b101);
    assign acc_next = mul_b[0] ? (acc + mul_a) : acc;
    assign mul_done = (state == CALC) && (cnt == CW'(WIDTH - 1));

    // Shift-add: one multiplier bit consumed per CALC edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept && is_mul) begin
            mul_a <= src_a;
            mul_b <= src_b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == CALC) begin
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            acc   <= acc_next;
            cnt   <= cnt + 1'b1;
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_MUL_EN
                    next_state = is_mul ? CALC : HOLD;
`else
                    next_state = HOLD;
`endif
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (!in_valid) begin
                        next_state = IDLE;
`ifdef ALU_MUL_EN
                    end else if (is_mul) begin
                        next_state = CALC;
`endif
                    end else begin
                        next_state = HOLD;
                    end
                end
            end
`ifdef ALU_MUL_EN
            CALC: begin
                if (mul_done) begin
                    next_state = HOLD;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (accept && !is_mul) begin
            result  <= op_result;
            zero    <= (op_result == '0);
            illegal <= op_illegal;
`ifdef ALU_MUL_EN
        end else if (mul_done) begin
            result  <= acc_next;
            zero    <= (acc_next == '0);
            illegal <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit: vector table plus
// hand-written backpressure, multiply and reset sequences.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
    } vec_t;

    vec_t vecs[12];

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_control(alu_control),
        .src_a      (src_a),
        .src_b      (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " result"}, result, 32'd0);
        chk({tag, " zero"}, 32'(zero), 32'd0);
        chk({tag, " illegal"}, 32'(illegal), 32'd0);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic seen;

        vecs[0]  = '{"add", 3'b000, 32'h0000_0005, 32'h0000_0003,
                     32'h0000_0008, 1'b0, 1'b0};
        vecs[1]  = '{"sub", 3'b001, 32'h0000_0000, 32'h0000_0001,
                     32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[2]  = '{"slt_neg", 3'b100, 32'hFFFF_FFFF, 32'h0000_0001,
                     32'h0000_0001, 1'b0, 1'b0};
        vecs[3]  = '{"slt_pos", 3'b100, 32'h0000_0001, 32'hFFFF_FFFF,
                     32'h0000_0000, 1'b1, 1'b0};
        vecs[4]  = '{"slt_min", 3'b100, 32'h8000_0000, 32'h7FFF_FFFF,
                     32'h0000_0001, 1'b0, 1'b0};
        vecs[5]  = '{"add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001,
                     32'h0000_0000, 1'b1, 1'b0};
        vecs[6]  = '{"or", 3'b011, 32'hF0F0_0000, 32'h0000_000F,
                     32'hF0F0_000F, 1'b0, 1'b0};
        vecs[7]  = '{"and", 3'b010, 32'hFFFF_0000, 32'h0F0F_0F0F,
                     32'h0F0F_0000, 1'b0, 1'b0};
        vecs[8]  = '{"sub_eq", 3'b001, 32'h0000_0005, 32'h0000_0005,
                     32'h0000_0000, 1'b1, 1'b0};
        vecs[9]  = '{"rsv111", 3'b111, 32'h0000_1234, 32'h0000_5678,
                     32'h0000_0000, 1'b1, 1'b1};
        vecs[10] = '{"rsv110", 3'b110, 32'h0000_1234, 32'h0000_5678,
                     32'h0000_0000, 1'b1, 1'b1};
        vecs[11] = '{"slt_eq", 3'b100, 32'h8000_0000, 32'h8000_0000,
                     32'h0000_0000, 1'b1, 1'b0};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        alu_control = 3'b000;
        src_a       = '0;
        src_b       = '0;
        step();
        step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Back-to-back vectors with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            alu_control = vecs[i].ctrl;
            src_a       = vecs[i].a;
            src_b       = vecs[i].b;
            in_valid    = 1'b1;
            #1;
            chk({vecs[i].name, " in_ready"}, 32'(in_ready), 32'd1);
            step();
            chk({vecs[i].name, " out_valid"}, 32'(out_valid), 32'd1);
            chk({vecs[i].name, " result"}, result, vecs[i].res);
            chk({vecs[i].name, " zero"}, 32'(zero), 32'(vecs[i].z));
            chk({vecs[i].name, " illegal"}, 32'(illegal),
                32'(vecs[i].ill));
        end
        in_valid = 1'b0;
        step();
        chk("drain out_valid", 32'(out_valid), 32'd0);
        chk("drain result kept", result, 32'h0000_0000);
        chk("drain illegal kept", 32'(illegal), 32'd0);

        // Backpressure: AND held while out_ready low
        out_ready   = 1'b0;
        alu_control = 3'b010;
        src_a       = 32'hF0F0_F0F0;
        src_b       = 32'h0F0F_0F0F;
        in_valid    = 1'b1;
        step();
        alu_control = 3'b000;
        src_a       = 32'h0000_0001;
        src_b       = 32'h0000_0001;
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp result", result, 32'h0000_0000);
            chk("bp zero", 32'(zero), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp retire out_valid", 32'(out_valid), 32'd0);
        chk("bp retire result kept", result, 32'h0000_0000);

        // Code 101: multiply when enabled, reserved otherwise
        alu_control = 3'b101;
        src_a       = 32'h0001_0003;
        src_b       = 32'h0000_0007;
        in_valid    = 1'b1;
        step();
        in_valid = 1'b0;
`ifdef ALU_MUL_EN
        cyc  = 1;
        seen = 1'b0;
        while (!out_valid && cyc < 100) begin
            if (in_ready) seen = 1'b1;
            step();
            cyc++;
        end
        chk("mul in_ready low", 32'(seen), 32'd0);
        chk("mul latency", 32'(cyc), 32'd32);
        chk("mul result", result, 32'h0007_0015);
        chk("mul zero", 32'(zero), 32'd0);
        chk("mul illegal", 32'(illegal), 32'd0);
`else
        cyc  = 0;
        seen = 1'b0;
        chk("mul101 out_valid", 32'(out_valid), 32'd1);
        chk("mul101 result", result, 32'h0000_0000);
        chk("mul101 zero", 32'(zero), 32'd1);
        chk("mul101 illegal", 32'(illegal), 32'd1);
`endif
        step();
        chk("mul retire", 32'(out_valid), 32'd0);

        // Async reset while a result is held
        out_ready   = 1'b0;
        alu_control = 3'b000;
        src_a       = 32'h0000_0005;
        src_b       = 32'h0000_0003;
        in_valid    = 1'b1;
        step();
        in_valid = 1'b0;
        chk("hold pre-reset", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("hold reset");
        #1;
        rst_n = 1'b1;
        step();
        chk("hold post-reset", 32'(out_valid), 32'd0);

`ifdef ALU_MUL_EN
        // Async reset during an in-flight multiply
        out_ready   = 1'b1;
        alu_control = 3'b101;
        src_a       = 32'h0000_0003;
        src_b       = 32'h0000_0005;
        in_valid    = 1'b1;
        step();
        in_valid = 1'b0;
        chk("calc in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("calc reset");
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("calc no stale result", 32'(seen), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
